// File: rtl/ehl_timer_cpt_fifo.sv
// Show-ahead FIFO for timer capture samples, with overflow/stop sticky status
// and a registered interrupt line.
module ehl_timer_cpt_fifo #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  tmr_clk,
    input  logic                  tmr_reset,
    input  logic                  capture,
    input  logic [WIDTH-1:0]      tmr_cpt,
    input  logic                  stop,
    input  logic                  flush,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  rd_valid,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full,
    input  logic [DEPTH_LOG2:0]   thr,
    input  logic [2:0]            irq_en,
    input  logic [2:0]            irq_clr,
    output logic [2:0]            irq_status,
    output logic                  irq
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0]   rd_ptr_q, rd_ptr_d;
    logic                  ovf_q, ovf_d;
    logic                  stp_q, stp_d;
    logic                  irq_q, irq_d;

    logic [DEPTH_LOG2-1:0] wr_idx, rd_idx;
    logic                  empty, full_w;
    logic                  push, pop, ovf_evt;
    logic [DEPTH_LOG2:0]   level_d;
    logic                  thr_hit, thr_hit_d;
    logic [2:0]            status_d;

    assign wr_idx = wr_ptr_q[DEPTH_LOG2-1:0];
    assign rd_idx = rd_ptr_q[DEPTH_LOG2-1:0];
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full_w = (wr_idx == rd_idx) && (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]);

    // A pop in the same cycle frees a slot, so a capture at full is still accepted.
    assign pop     = rd_en && !empty;
    assign push    = capture && (!full_w || pop);
    assign ovf_evt = capture && full_w && !pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Set beats clear; flush clears overflow but leaves the stop flag alone.
    always_comb begin
        ovf_d = ovf_q;
        if (flush)             ovf_d = 1'b0;
        else if (ovf_evt)      ovf_d = 1'b1;
        else if (irq_clr[1])   ovf_d = 1'b0;

        stp_d = stp_q;
        if (stop)              stp_d = 1'b1;
        else if (irq_clr[2])   stp_d = 1'b0;
    end

    assign level_d   = wr_ptr_d - rd_ptr_d;
    assign thr_hit_d = (thr != '0) && (level_d >= thr);
    assign status_d  = {stp_d, ovf_d, thr_hit_d};
    assign irq_d     = |(status_d & irq_en);

    always_ff @(posedge tmr_clk) begin
        if (tmr_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            stp_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            stp_q    <= stp_d;
            irq_q    <= irq_d;
        end
    end

    // Storage is deliberately left unreset; pointers alone define validity.
    always_ff @(posedge tmr_clk) begin
        if (!tmr_reset && !flush && push) begin
            mem_q[wr_idx] <= tmr_cpt;
        end
    end

    assign level      = wr_ptr_q - rd_ptr_q;
    assign thr_hit    = (thr != '0) && (level >= thr);
    assign full       = full_w;
    assign rd_valid   = !empty;
    assign rd_data    = empty ? '0 : mem_q[rd_idx];
    assign irq_status = {stp_q, ovf_q, thr_hit};
    assign irq        = irq_q;

endmodule

// File: doc/ehl_timer_cpt_fifo.md
Name: ehl_timer_cpt_fifo

Overview:
Capture-sample buffer that sits directly downstream of the timer core. It takes the core's one-cycle `capture` pulse and captured value `tmr_cpt`, and queues the samples in a show-ahead FIFO. It also tracks overflow and end-of-capture (`stop`) events, and produces a single registered interrupt for the CSR/bus layer. Back-to-back captures are therefore not lost between software reads.

Parameters:
- WIDTH, 32: width of captured timer value.
- DEPTH_LOG2, 2: log2 of FIFO depth. Depth = 2**DEPTH_LOG2. Legal range 1..6.

Ports:
- tmr_clk  input  1  timer clock; the same undivided clock the timer core uses for its event pulses.
- tmr_reset  input  1  reset. Synchronous, active-high.
- capture  input  1  capture event pulse from the timer core, 1 tmr_clk cycle wide.
- tmr_cpt  input  WIDTH  captured timer value; valid in the cycle `capture` is high.
- stop  input  1  stop pulse from the timer core (end of capture / expiry).
- flush  input  1  discard all entries and clear ovf.
- rd_en  input  1  pop the oldest entry.
- rd_data  output  WIDTH  oldest entry (show-ahead).
- rd_valid  output  1  FIFO not empty.
- level  output  DEPTH_LOG2+1  number of stored entries.
- full  output  1  level == depth.
- thr  input  DEPTH_LOG2+1  level threshold for interrupt; 0 disables the threshold source.
- irq_en  input  3  interrupt enable per status bit.
- irq_clr  input  3  write-1-to-clear for the sticky status bits [2:1].
- irq_status  output  3
  - [0]: threshold reached, level-sensitive.
  - [1]: overflow, sticky.
  - [2]: stop seen, sticky.
- irq  output  1  registered OR of (irq_status & irq_en).

Behaviour:
- Clocking and reset:
  - Single clock domain, tmr_clk.
  - All flops reset synchronously when tmr_reset=1.
  - Reset values: read/write pointers=0, level=0, full=0, rd_valid=0, irq_status=3'b000, irq=0.
  - Storage contents are not reset; rd_data=0 while empty.
  - A reset asserted mid-operation discards all entries on the next edge.
- Storage:
  - Array of 2**DEPTH_LOG2 entries, WIDTH bits each.
  - Write pointer and read pointer are DEPTH_LOG2+1 bits with a wrap bit.
  - empty = pointers equal.
  - full = indices equal and wrap bits differ.
  - level = wr_ptr - rd_ptr, modulo 2**(DEPTH_LOG2+1).
- Push:
  - `capture`=1 and not full: entry[wr_idx] <= tmr_cpt, wr_ptr+1.
  - Visible at rd_data/rd_valid/level one cycle after the capture edge.
- Pop:
  - rd_en=1 and rd_valid=1: rd_ptr+1; rd_data moves to the next entry in the same edge.
  - rd_en while empty is ignored: no pointer change, no error flag.
- Simultaneous push and pop:
  - Both are performed and level is unchanged.
  - This also applies when full: the pop frees a slot, the push is accepted, no overflow.
  - When empty with push and pop together, only the push takes effect (the pop is ignored).
- Overflow:
  - `capture`=1 while full with no pop: the new sample is dropped and stored data is preserved.
  - irq_status[1] <= 1.
- Stop: `stop`=1 sets irq_status[2] <= 1.
- Threshold:
  - irq_status[0] = (thr != 0) && (level >= thr).
  - Combinational from registered level; not clearable by irq_clr.
- Sticky-bit clear:
  - irq_clr[k]=1 clears bit k (k=1,2) on the next edge.
  - If a set event and a clear for the same bit occur in the same cycle, the set wins.
  - irq_clr[0] has no effect.
- Flush:
  - flush=1 sets both pointers to 0 and clears irq_status[1] on the next edge.
  - Flush has priority over push/pop in the same cycle; a capture in the flush cycle is discarded.
  - irq_status[2] is unaffected by flush.
- Interrupt:
  - irq <= |(irq_status_next & irq_en), registered.
  - irq rises one edge after the triggering event edge.

Test Plan:
- Fill: reset, DEPTH_LOG2=2, four captures of 0x10, 0x20, 0x30, 0x40 → level=4, full=1, rd_data=0x10; four pops → rd_data 0x20, 0x30, 0x40 in turn, then rd_valid=0, level=0.
- Overflow: at full, capture 0x50 → data unchanged, irq_status[1]=1; with irq_en=3'b010, irq=1 the next cycle; irq_clr=3'b010 → status[1]=0, irq=0 one cycle later.
- Full push+pop: at full, capture 0x60 with rd_en in the same cycle → no overflow, level stays 4; after three more pops rd_data=0x60.
- Threshold: thr=2, irq_en=3'b001; two captures → irq_status[0]=1, irq=1; one pop → status[0]=0, irq=0; thr=0 with level=4 → status[0]=0.
- Set-vs-clear and flush: stop pulse with irq_clr[2] in the same cycle → status[2]=1; flush with capture in the same cycle → level=0, ovf=0, status[2] still 1.
- Reset mid-fill: two captures, then tmr_reset for 1 cycle → level=0, rd_valid=0, irq=0, irq_status=0; a subsequent capture of 0xAA → rd_data=0xAA.
